// File: rtl/tl_pkg.sv
// Shared types, light encodings and duration helpers for the intersection scheduler.
package tl_pkg;

  localparam int TL_MAX_W = 64;

  typedef enum logic [2:0] {
    A_GREEN  = 3'd0,
    A_YELLOW = 3'd1,
    CLR_AB   = 3'd2,
    B_GREEN  = 3'd3,
    B_YELLOW = 3'd4,
    CLR_BA   = 3'd5
  } phase_e;

  localparam logic [2:0] LT_GREEN  = 3'b100;
  localparam logic [2:0] LT_YELLOW = 3'b010;
  localparam logic [2:0] LT_RED    = 3'b001;

  function automatic logic [TL_MAX_W-1:0] eff_dur(input logic [TL_MAX_W-1:0] x,
                                                 input logic [TL_MAX_W-1:0] floor_v);
    return (x < floor_v) ? floor_v : x;
  endfunction

  function automatic phase_e next_phase(input phase_e p);
    case (p)
      A_GREEN:  return A_YELLOW;
      A_YELLOW: return CLR_AB;
      CLR_AB:   return B_GREEN;
      B_GREEN:  return B_YELLOW;
      B_YELLOW: return CLR_BA;
      default:  return A_GREEN;
    endcase
  endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// Phase timer: latches the phase duration on load and counts cycles elapsed in the phase.
module tl_phase_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             saturate,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] dur_q;

  // load_val is always >= 1, so dur_q - 1 never wraps
  assign done = (cnt_q == dur_q - ONE);
  assign cnt  = cnt_q;

  always_ff @(posedge clk) begin
    if (load) begin
      cnt_q <= '0;
      dur_q <= load_val;
    end else if (!done) begin
      cnt_q <= cnt_q + ONE;
    end else if (!saturate) begin
      cnt_q <= '0;
    end
  end

endmodule

// File: rtl/intersection_scheduler.sv
// Two-approach intersection phase scheduler (main road A, side road B).
// Optional pedestrian walk support is enabled with the TL_PED_WALK_EN macro.
module intersection_scheduler
  import tl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MIN_GREEN_A = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] durGreen,
  input  logic [CNT_W-1:0] durYellow,
  input  logic [CNT_W-1:0] durAllRed,
  input  logic             side_req,
`ifdef TL_PED_WALK_EN
  input  logic             ped_req,
  output logic             walk,
`endif
  output logic [2:0]       lightA,
  output logic [2:0]       lightB,
  output logic [2:0]       phase_q,
  output logic [CNT_W-1:0] cnt_q,
  output logic             req_pend
);

  phase_e           phase_r, phase_d, tgt;
  logic             done, advance, req_in, tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic [2:0]       light_a_d, light_b_d;

`ifdef TL_PED_WALK_EN
  assign req_in = side_req | ped_req;
`else
  assign req_in = side_req;
`endif

  assign phase_q = phase_r;

  tl_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .load     (tmr_load),
    .load_val (tmr_val),
    .saturate (phase_r == A_GREEN),
    .cnt      (cnt_q),
    .done     (done)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      phase_r  <= CLR_BA;
      req_pend <= 1'b0;
    end else begin
      phase_r <= phase_d;
      // the clear on B_GREEN entry wins over a coincident request
      if (advance && phase_d == B_GREEN)
        req_pend <= 1'b0;
      else if (phase_r != B_GREEN && req_in)
        req_pend <= 1'b1;
    end
    lightA <= light_a_d;
    lightB <= light_b_d;
  end

  // tgt is the phase being held or entered; reset forces the all-red entry
  always_comb begin
    advance  = (phase_r == A_GREEN) ? (done && (req_pend || req_in)) : done;
    phase_d  = advance ? next_phase(phase_r) : phase_r;
    tgt      = reset ? phase_d : CLR_BA;
    tmr_load = !reset || advance;
    case (tgt)
      A_GREEN:            tmr_val = CNT_W'(eff_dur(TL_MAX_W'(durGreen), TL_MAX_W'(MIN_GREEN_A)));
      B_GREEN:            tmr_val = CNT_W'(eff_dur(TL_MAX_W'(durGreen), TL_MAX_W'(1)));
      A_YELLOW, B_YELLOW: tmr_val = CNT_W'(eff_dur(TL_MAX_W'(durYellow), TL_MAX_W'(1)));
      default:            tmr_val = CNT_W'(eff_dur(TL_MAX_W'(durAllRed), TL_MAX_W'(1)));
    endcase
  end

  always_comb begin
    light_a_d = LT_RED;
    light_b_d = LT_RED;
    case (tgt)
      A_GREEN:  light_a_d = LT_GREEN;
      A_YELLOW: light_a_d = LT_YELLOW;
      B_GREEN:  light_b_d = LT_GREEN;
      B_YELLOW: light_b_d = LT_YELLOW;
      default:  ;
    endcase
  end

`ifdef TL_PED_WALK_EN
  logic [TL_MAX_W-1:0] walk_dg, walk_dy, walk_len;
  logic [CNT_W-1:0]    walk_rem;

  always_comb begin
    walk_dg  = eff_dur(TL_MAX_W'(durGreen), TL_MAX_W'(1));
    walk_dy  = eff_dur(TL_MAX_W'(durYellow), TL_MAX_W'(1));
    walk_len = (walk_dg > walk_dy) ? (walk_dg - walk_dy) : TL_MAX_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      walk     <= 1'b0;
      walk_rem <= '0;
    end else if (advance && phase_d == B_GREEN) begin
      walk     <= 1'b1;
      walk_rem <= CNT_W'(walk_len - TL_MAX_W'(1));
    end else if (phase_r == B_GREEN && walk_rem != '0) begin
      walk_rem <= walk_rem - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      walk <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_intersection_scheduler.sv
// Directed bench for intersection_scheduler with hand-computed phase timing.
module tb_intersection_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] durGreen, durYellow, durAllRed;
  logic        side_req;
  logic [2:0]  lightA, lightB, phase_q;
  logic [31:0] cnt_q;
  logic        req_pend;
  logic        chk_en = 1'b0;
  int          checks = 0;
  int          failures = 0;
`ifdef TL_PED_WALK_EN
  logic        ped_req;
  logic        walk;
`endif

  intersection_scheduler #(.CNT_W(32), .MIN_GREEN_A(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .durGreen  (durGreen),
    .durYellow (durYellow),
    .durAllRed (durAllRed),
    .side_req  (side_req),
`ifdef TL_PED_WALK_EN
    .ped_req   (ped_req),
    .walk      (walk),
`endif
    .lightA    (lightA),
    .lightB    (lightB),
    .phase_q   (phase_q),
    .cnt_q     (cnt_q),
    .req_pend  (req_pend)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_phase(input logic [2:0] ph, input int n);
    for (int i = 0; i < n; i++) begin
      check("phase", 32'(phase_q), 32'(ph));
      check("cnt", cnt_q, 32'(i));
      tick();
    end
  endtask

  always @(negedge clk)
    if (chk_en)
      check("safety", 32'(lightA != 3'b001 && lightB != 3'b001), 32'd0);

  initial begin
    reset = 1'b0; side_req = 1'b0;
    durGreen = 32'd4; durYellow = 32'd2; durAllRed = 32'd1;
`ifdef TL_PED_WALK_EN
    ped_req = 1'b0;
`endif
    repeat (3) tick();
    chk_en = 1'b1;
    check("rst_lightA", 32'(lightA), 32'd1);
    check("rst_lightB", 32'(lightB), 32'd1);
    check("rst_phase", 32'(phase_q), 32'd5);
    check("rst_cnt", cnt_q, 32'd0);
    check("rst_req", 32'(req_pend), 32'd0);

    reset = 1'b1;
    tick();
    check("rel_phase", 32'(phase_q), 32'd0);
    check("rel_lightA", 32'(lightA), 32'd4);
    check("rel_lightB", 32'(lightB), 32'd1);

    repeat (50) tick();
    check("idle_lightA", 32'(lightA), 32'd4);
    check("idle_lightB", 32'(lightB), 32'd1);
    check("idle_cnt", cnt_q, 32'd3);

    reset = 1'b0; tick();
    reset = 1'b1; tick();
    check("fc_cnt0", cnt_q, 32'd0);
    tick();
    check("fc_cnt1", cnt_q, 32'd1);
    side_req = 1'b1; tick(); side_req = 1'b0;
    check("fc_req", 32'(req_pend), 32'd1);
    check("fc_cnt2", cnt_q, 32'd2);
    tick();
    check("fc_cnt3", cnt_q, 32'd3);
    check("fc_ph3", 32'(phase_q), 32'd0);
    tick();
    check("fc_ayel_A", 32'(lightA), 32'd2);
    run_phase(3'd1, 2);
    run_phase(3'd2, 1);
    check("fc_req_clr", 32'(req_pend), 32'd0);
    check("fc_bg_B", 32'(lightB), 32'd4);
    check("fc_bg_A", 32'(lightA), 32'd1);
    run_phase(3'd3, 4);
    check("fc_byel_B", 32'(lightB), 32'd2);
    run_phase(3'd4, 2);
    run_phase(3'd5, 1);
    check("fc_back", 32'(phase_q), 32'd0);
    check("fc_back_A", 32'(lightA), 32'd4);

    repeat (3) tick();
    check("sim_cnt3", cnt_q, 32'd3);
    side_req = 1'b1; tick(); side_req = 1'b0;
    check("sim_phase", 32'(phase_q), 32'd1);
    check("sim_lightA", 32'(lightA), 32'd2);
    run_phase(3'd1, 2);
    run_phase(3'd2, 1);
    check("mid_ph", 32'(phase_q), 32'd3);
    tick();
    durGreen = 32'd10;
    for (int i = 1; i < 4; i++) begin
      check("mid_bg_ph", 32'(phase_q), 32'd3);
      check("mid_bg_cnt", cnt_q, 32'(i));
      tick();
    end
    check("mid_byel", 32'(phase_q), 32'd4);
    check("mid_byel_B", 32'(lightB), 32'd2);

    reset = 1'b0; tick();
    check("mrst_lightA", 32'(lightA), 32'd1);
    check("mrst_lightB", 32'(lightB), 32'd1);
    check("mrst_phase", 32'(phase_q), 32'd5);
    check("mrst_cnt", cnt_q, 32'd0);
    check("mrst_req", 32'(req_pend), 32'd0);

    durGreen = 32'd0; durYellow = 32'd0; durAllRed = 32'd0;
    side_req = 1'b1;
    tick();
    reset = 1'b1;
    run_phase(3'd5, 1);
    run_phase(3'd0, 2);
    run_phase(3'd1, 1);
    run_phase(3'd2, 1);
    check("bnd_req_clr", 32'(req_pend), 32'd0);
    run_phase(3'd3, 1);
    check("bnd_req_ign", 32'(req_pend), 32'd0);
    run_phase(3'd4, 1);
    check("bnd_req_set", 32'(req_pend), 32'd1);
    run_phase(3'd5, 1);
    run_phase(3'd0, 2);
    check("bnd_ayel", 32'(phase_q), 32'd1);
    side_req = 1'b0;

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/intersection_scheduler.md
Name: intersection_scheduler

Overview:
- Two-approach intersection phase scheduler: main road A and side road B.
- Sequences green/yellow/all-red phases from runtime duration inputs.
- A rests on green until a latched side-road request arrives.
- Top-level controller above the single-light counter; drives both light sets and exposes phase/count for debug.

Parameters:
- CNT_W, 32, width of duration inputs and phase counter.
- MIN_GREEN_A, 2, minimum main-green cycles; applied as the floor on the effective A green duration.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- durGreen  input  CNT_W  green duration in cycles; applies to A and B.
- durYellow  input  CNT_W  yellow duration in cycles.
- durAllRed  input  CNT_W  all-red clearance duration in cycles.
- side_req  input  1  side-road vehicle sensor; level or 1-cycle pulse.
- lightA  output  3  {green, yellow, red}, one-hot, registered.
- lightB  output  3  {green, yellow, red}, one-hot, registered.
- phase_q  output  3  current phase encoding (tl_pkg::phase_e).
- cnt_q  output  CNT_W  cycles elapsed in current phase.
- req_pend  output  1  latched side request pending.

Behaviour:
- Phases: A_GREEN=0, A_YELLOW=1, CLR_AB=2, B_GREEN=3, B_YELLOW=4, CLR_BA=5.
- Cyclic order: A_GREEN -> A_YELLOW -> CLR_AB -> B_GREEN -> B_YELLOW -> CLR_BA -> A_GREEN.
- Reset (reset==0 at edge):
  - phase=CLR_BA, cnt_q=0, req_pend=0.
  - lightA=lightB=3'b001 (both red).
- After reset release: CLR_BA lasts D(durAllRed) cycles, then A_GREEN.
- Effective duration D(x) = max(x,1). For A_GREEN only, D = max(durGreen, MIN_GREEN_A).
- Durations are latched on phase entry. Input changes mid-phase take effect at the next phase entry.
- cnt_q is 0 in the first cycle of a phase and increments each cycle.
- Timed phases: at the edge where cnt_q==D-1, advance to the next phase and set cnt_q=0. Every phase except A_GREEN lasts exactly D cycles.
- A_GREEN:
  - Timer expires when cnt_q==D-1. cnt_q then saturates at D-1.
  - Exit to A_YELLOW at the first edge where the timer has expired AND (req_pend | side_req).
- req_pend:
  - Set by side_req in any phase except B_GREEN.
  - Cleared on the edge entering B_GREEN.
  - side_req during B_GREEN is ignored.
  - side_req coinciding with the clear edge is dropped.
- Simultaneous events: side_req asserted in the same cycle A_GREEN expires causes the exit on that same edge (no extra cycle).
- Outputs are registered and reflect the current phase:
  - A_GREEN: A=100, B=001.
  - A_YELLOW: A=010, B=001.
  - CLR_AB/CLR_BA: A=001, B=001.
  - B_GREEN: A=001, B=100.
  - B_YELLOW: A=001, B=010.
- Safety invariant: lightA and lightB never both non-red in the same cycle.
- Reset mid-phase: immediate return to the reset state on the next edge; no partial yellow.
- Arithmetic: counter is CNT_W bits. D-1 is computed after the max(), so there is no underflow.

Optional Feature:
- Macro: TL_PED_WALK_EN.
- Defined:
  - Adds input ped_req and output walk (1 bit).
  - ped_req sets req_pend exactly as side_req does.
  - walk=1 during the first D(durGreen)-D(durYellow) cycles of B_GREEN, floored at 1 cycle; otherwise 0.
  - walk resets to 0.
- Undefined: neither port exists; behaviour is otherwise identical.

Decomposition:
- Package tl_pkg:
  - phase_e enum (3-bit).
  - Light constants LT_GREEN=3'b100, LT_YELLOW=3'b010, LT_RED=3'b001.
  - Function eff_dur(x, floor).
- One sub-module, tl_phase_timer:
  - Inputs: load, load_val, saturate.
  - Outputs: cnt, done.
  - Owns cnt_q and the duration latch; instantiated once.

Test Plan:
- Reset hold: reset=0 for 3 cycles -> A=B=001, phase=5, cnt_q=0, req_pend=0. Release with durAllRed=1 -> A_GREEN (A=100) after 1 cycle.
- No demand: durGreen=4, side_req=0 for 50 cycles -> A stays 100, cnt_q saturates at 3, B stays 001.
- Full cycle:
  - Setup: G=4, Y=2, R=1; side_req pulsed 1 cycle at cnt_q=1 of A_GREEN.
  - Required: A_GREEN total 4 cycles, A_YELLOW 2, CLR_AB 1, B_GREEN 4, B_YELLOW 2, CLR_BA 1, then A_GREEN.
  - req_pend clears on B_GREEN entry.
- Simultaneous: side_req first asserted at cnt_q==3 of A_GREEN (G=4) -> A_YELLOW on the very next edge.
- Boundaries:
  - durYellow=0, durAllRed=0 -> each lasts 1 cycle.
  - durGreen=0 -> A_GREEN lasts MIN_GREEN_A=2 cycles; B_GREEN lasts 1.
  - durGreen changed mid-B_GREEN -> current phase unaffected.
- Mid-operation reset: reset=0 during B_YELLOW -> next cycle A=B=001, phase=5. The safety invariant holds in every cycle of every test.
